// File: rtl/reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter_if
// Bundles the requester-side and Reg-side signals of the shared write port.
//   req    : per-requester write request (level)
//   lock   : per-requester request to keep the grant after the current write
//   data   : packed write data, requester k at [k*WIDTH +: WIDTH]
//   grant  : one-hot registered grant back to the winning requester
//   reg_in : registered data to the shared Reg `in`
//   reg_we : registered write strobe to the shared Reg
//   busy   : high while a requester owns the port in locked mode
// Modports: master = requesters/Reg side, slave = arbiter.
// -----------------------------------------------------------------------------
interface reg_write_arbiter_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0]       lock;
    logic [NUM_REQ*WIDTH-1:0] data;
    logic [NUM_REQ-1:0]       grant;
    logic [WIDTH-1:0]         reg_in;
    logic                     reg_we;
    logic                     busy;

    modport master (
        output req, lock, data,
        input  grant, reg_in, reg_we, busy
    );

    modport slave (
        input  req, lock, data,
        output grant, reg_in, reg_we, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin arbiter sharing one Reg write port between NUM_REQ requesters.
// A winner chosen on edge n drives grant/reg_we/reg_in during cycle n+1.
// A winner with lock set keeps the port (LOCKED) for back-to-back writes.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : reg_write_arbiter_if.slave (req, lock, data in; grant, reg_in,
//           reg_we, busy out, all outputs registered)
//
// Optional feature macro: REG_ARB_LOCK_TIMEOUT_EN
//   defined   : a locked owner is forcibly released after MAX_LOCK grants
//   undefined : no lock counter; release only when req or lock drops
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_write_arbiter_if.slave   bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Elaboration-time parameter range guard.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LOCK < 2 || MAX_LOCK > 255) begin : g_bad_param
            $error("reg_write_arbiter: parameter out of range");
        end
    endgenerate

    // Index of the requester following i, wrapping modulo NUM_REQ.
    function automatic logic [IW-1:0] next_idx_f(input logic [IW-1:0] i);
        logic [IW-1:0] n;
        if (i == IW'(NUM_REQ - 1)) begin
            n = {IW{1'b0}};
        end else begin
            n = i + {{(IW-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    // Round-robin search: first set bit of r starting at start. Returns {found, index}.
    function automatic logic [IW:0] pick_f(input logic [NUM_REQ-1:0] r,
                                           input logic [IW-1:0]      start);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] sel;
        found = 1'b0;
        sel   = {IW{1'b0}};
        idx   = start;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[idx]) begin
                found = 1'b1;
                sel   = idx;
            end else begin
                found = found;
            end
            idx = next_idx_f(idx);
        end
        return {found, sel};
    endfunction

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      ptr_q,   ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [WIDTH-1:0]   reg_in_q, reg_in_d;
    logic               reg_we_q, reg_we_d;
    logic               busy_q,  busy_d;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
    localparam logic [7:0] MAX_LOCK_C = 8'(MAX_LOCK);
    logic [7:0]         cnt_q, cnt_d;
`endif

    logic               arb_en_s;
    logic [NUM_REQ-1:0] arb_mask_s;
    logic [IW-1:0]      arb_start_s;
    logic [IW:0]        pick_s;
    logic [IW-1:0]      win_s;
    logic               hold_ok_s;

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        grant_d     = {NUM_REQ{1'b0}};
        reg_in_d    = reg_in_q;
        reg_we_d    = 1'b0;
        arb_en_s    = 1'b0;
        arb_mask_s  = bus.req;
        arb_start_s = ptr_q;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
        cnt_d       = cnt_q;
        hold_ok_s   = (cnt_q < MAX_LOCK_C);
`else
        hold_ok_s   = 1'b1;
`endif

        case (state_q)
            ST_IDLE: begin
                arb_en_s = 1'b1;
            end
            ST_LOCKED: begin
                if (bus.req[owner_q] && hold_ok_s) begin
                    grant_d  = ONE_HOT0 << owner_q;
                    reg_in_d = bus.data[int'(owner_q)*WIDTH +: WIDTH];
                    reg_we_d = 1'b1;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                    cnt_d    = cnt_q + 8'd1;
`endif
                    // Dropping lock with req still high makes this the owner's last write.
                    if (!bus.lock[owner_q]) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_idx_f(owner_q);
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                        cnt_d   = 8'd0;
`endif
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end else begin
                    // Release without a write to the owner; re-arbitrate among the
                    // others in the same cycle so no bubble is inserted.
                    state_d     = ST_IDLE;
                    ptr_d       = next_idx_f(owner_q);
`ifdef REG_ARB_LOCK_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                    arb_en_s    = 1'b1;
                    arb_mask_s  = bus.req & ~(ONE_HOT0 << owner_q);
                    arb_start_s = next_idx_f(owner_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pick_s = pick_f(arb_mask_s, arb_start_s);
        win_s  = pick_s[IW-1:0];

        if (arb_en_s && pick_s[IW]) begin
            grant_d  = ONE_HOT0 << win_s;
            reg_in_d = bus.data[int'(win_s)*WIDTH +: WIDTH];
            reg_we_d = 1'b1;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
            cnt_d    = 8'd1;
`endif
            // A locked winner keeps ptr unchanged; it advances when the lock ends.
            if (bus.lock[win_s]) begin
                state_d = ST_LOCKED;
                owner_d = win_s;
            end else begin
                ptr_d   = next_idx_f(win_s);
            end
        end else begin
            grant_d = grant_d;
        end

        busy_d = (state_d == ST_LOCKED);
    end

    // State and registered outputs; asynchronous reset drops any pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= {IW{1'b0}};
            ptr_q    <= {IW{1'b0}};
            grant_q  <= {NUM_REQ{1'b0}};
            reg_in_q <= {WIDTH{1'b0}};
            reg_we_q <= 1'b0;
            busy_q   <= 1'b0;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
            cnt_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            reg_in_q <= reg_in_d;
            reg_we_q <= reg_we_d;
            busy_q   <= busy_d;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.grant  = grant_q;
    assign bus.reg_in = reg_in_q;
    assign bus.reg_we = reg_we_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
module tb_reg_write_arbiter;

    localparam int WIDTH    = 8;
    localparam int NUM_REQ  = 4;
    localparam int MAX_LOCK = 8;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
    localparam int LIM = MAX_LOCK;
`else
    localparam int LIM = 1 << 30;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bif();

    reg_write_arbiter #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural view: who owns the port, where the search starts, how many
    // grants the current lock has used, and what the outputs must show.
    typedef struct {
        bit         locked;
        int         owner;
        int         ptr;
        int         run;
        logic [3:0] grant;
        logic [7:0] reg_in;
        bit         we;
    } model_t;

    function automatic model_t step(model_t m, logic [3:0] r, logic [3:0] l, logic [31:0] d);
        model_t n;
        int excl;
        int w;
        n = m;
        excl = -1;
        w = -1;
        n.grant = 4'b0000;
        n.we = 1'b0;
        if (m.locked) begin
            if (r[m.owner] && m.run < LIM) begin
                n.grant  = 4'b0001 << m.owner;
                n.reg_in = d[m.owner*8 +: 8];
                n.we     = 1'b1;
                n.run    = m.run + 1;
                if (!l[m.owner]) begin
                    n.locked = 1'b0;
                    n.ptr    = (m.owner + 1) % NUM_REQ;
                end
                return n;
            end
            n.locked = 1'b0;
            n.ptr    = (m.owner + 1) % NUM_REQ;
            excl     = m.owner;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (n.ptr + k) % NUM_REQ;
            if (w < 0 && r[i] && i != excl) w = i;
        end
        if (w >= 0) begin
            n.grant  = 4'b0001 << w;
            n.reg_in = d[w*8 +: 8];
            n.we     = 1'b1;
            n.run    = 1;
            if (l[w]) begin
                n.locked = 1'b1;
                n.owner  = w;
            end else begin
                n.ptr = (w + 1) % NUM_REQ;
            end
        end
        return n;
    endfunction

    model_t m;

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{default: 0};
        else        m <= step(m, bif.req, bif.lock, bif.data);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("grant",  32'(bif.grant),  32'(m.grant));
            cmp("reg_we", 32'(bif.reg_we), 32'(m.we));
            cmp("reg_in", 32'(bif.reg_in), 32'(m.reg_in));
            cmp("busy",   32'(bif.busy),   32'(m.locked));
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bif.req  = 4'b0000;
        bif.lock = 4'b0000;
        bif.data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bif.req  = 4'b1111;
        chk_en   = 1'b1;

        // Reset held with all requesting: outputs stay zero.
        repeat (4) begin
            @(negedge clk);
            cmp("rst_grant",  32'(bif.grant),  32'h0);
            cmp("rst_we",     32'(bif.reg_we), 32'h0);
            cmp("rst_reg_in", 32'(bif.reg_in), 32'h0);
        end
        reset = 1'b1;

        // Rotation across all four requesters starting at 0.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmp("rr_grant",  32'(bif.grant),  32'(1) << (i % 4));
            cmp("rr_reg_in", 32'(bif.reg_in), 32'hA0 + 32'(i % 4));
            cmp("rr_we",     32'(bif.reg_we), 32'h1);
        end

        // Two sparse requesters alternate, starting from requester 2.
        bif.req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cmp("alt_grant",  32'(bif.grant),  (i % 2 == 0) ? 32'h4  : 32'h1);
            cmp("alt_reg_in", 32'(bif.reg_in), (i % 2 == 0) ? 32'hA2 : 32'hA0);
        end
        bif.req = 4'b0000;
        @(negedge clk);
        cmp("idle_grant", 32'(bif.grant), 32'h0);

        // Requester 1 locks while requester 3 waits.
        bif.req  = 4'b1010;
        bif.lock = 4'b0010;
`ifdef REG_ARB_LOCK_TIMEOUT_EN
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (bif.grant == 4'b0010 && n < 40) begin
                n++;
                cmp("lock_busy", 32'(bif.busy), 32'h1);
                @(negedge clk);
            end
            cmp("lock_len",   32'(n),         32'd8);
            cmp("after_lock", 32'(bif.grant), 32'h8);
        end
`else
        for (int i = 1; i <= 19; i++) begin
            @(negedge clk);
            cmp("lock_grant", 32'(bif.grant), 32'h2);
            cmp("lock_busy",  32'(bif.busy),  32'h1);
        end
        bif.lock = 4'b0000;
        @(negedge clk);
        cmp("lock_final", 32'(bif.grant), 32'h2);
        @(negedge clk);
        cmp("after_lock", 32'(bif.grant), 32'h8);
`endif
        bif.req  = 4'b0000;
        bif.lock = 4'b0000;
        @(negedge clk);

        // Async reset mid-lock with owner 2.
        bif.req  = 4'b0100;
        bif.lock = 4'b0100;
        repeat (3) begin
            @(negedge clk);
            cmp("own2_grant", 32'(bif.grant), 32'h4);
            cmp("own2_busy",  32'(bif.busy),  32'h1);
        end
        #2 reset = 1'b0;
        #1;
        cmp("arst_grant", 32'(bif.grant),  32'h0);
        cmp("arst_we",    32'(bif.reg_we), 32'h0);
        cmp("arst_busy",  32'(bif.busy),   32'h0);
        bif.req  = 4'b1111;
        bif.lock = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cmp("restart_grant", 32'(bif.grant), 32'h1);

        // Randomised traffic with sticky locks and occasional async resets.
        repeat (2000) begin
            @(negedge clk);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!bif.req[k] || bif.grant[k]) bif.data[k*8 +: 8] = 8'($urandom);
                if ($urandom_range(0, 3) == 0) bif.req[k]  = ~bif.req[k];
                if ($urandom_range(0, 7) == 0) bif.lock[k] = ~bif.lock[k];
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
        end
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
